lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: checks alignment, drives a single-beat memory bus
// with a timeout, and returns one completion pulse per accepted request.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        lsu_VALID,
    output logic        lsu_READY,
    input  logic        i_st_mem,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: lsu_VALID is sampled only in IDLE; lsu_READY is a one-cycle
    // completion pulse. On the bus, o_mem_req holds with stable fields until a
    // one-cycle i_mem_ack, or until the timeout gives up on it.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [9:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] st_data_q;
    logic [2:0]  funct3_q;
    logic        st_q;
    logic [31:0] ld_q;
    logic        mis_q;
    logic        err_q;

    logic        req_ok;
    logic        busy;
    logic        resp;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    function automatic logic access_ok(input logic st, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic legal;
        logic aligned;
        legal   = 1'b0;
        aligned = 1'b1;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !st;
            default:                legal = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   aligned = !a[0];
            2'b10:   aligned = (a == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign req_ok = access_ok(i_st_mem, i_funct3, i_addr[1:0]);
    assign busy   = (state == BUSY);
    assign resp   = (state == RESP);

    // Store lanes follow the latched address so they stay stable through BUSY.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = st_data_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_be    = 4'b0001 << addr_q[1:0];
                store_wdata = {4{st_data_q[7:0]}};
            end
            2'b01: begin
                store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{st_data_q[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = st_data_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 10'd0;
            addr_q    <= 32'd0;
            st_data_q <= 32'd0;
            funct3_q  <= 3'd0;
            st_q      <= 1'b0;
            ld_q      <= 32'd0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ld_q  <= 32'd0;
                    mis_q <= 1'b0;
                    err_q <= 1'b0;
                    if (lsu_VALID) begin
                        if (req_ok) begin
                            addr_q    <= i_addr;
                            st_data_q <= i_st_data;
                            funct3_q  <= i_funct3;
                            st_q      <= i_st_mem;
                            cnt       <= 10'd0;
                            state     <= BUSY;
                        end else begin
                            mis_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle beats the timeout.
                    if (i_mem_ack) begin
                        ld_q  <= st_q ? 32'd0
                                      : load_extend(funct3_q, addr_q[1:0], i_mem_rdata);
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        ld_q  <= 32'd0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                RESP: begin
                    ld_q  <= 32'd0;
                    mis_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lsu_READY    = resp;
    assign o_ld_data    = resp ? ld_q : 32'd0;
    assign o_misaligned = resp & mis_q;
    assign o_bus_err    = resp & err_q;

    assign o_mem_req   = busy;
    assign o_mem_we    = busy & st_q;
    assign o_mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign o_mem_be    = busy ? (st_q ? store_be : 4'b1111) : 4'd0;
    assign o_mem_wdata = (busy && st_q) ? store_wdata : 32'd0;

    assign dbg_state = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// accesses compared against an arithmetic model of the load/store rules.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_VALID = 1'b0;
    logic        lsu_READY;
    logic        st_mem = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic [31:0] ld_data;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic        ready;
        logic [7:0]  latency;
        logic [31:0] ld;
        logic        mis;
        logic        err;
        logic [7:0]  req_cycles;
        logic [7:0]  idle_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        unstable;
        logic        leak;
    } obs_t;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .lsu_VALID    (lsu_VALID),
        .lsu_READY    (lsu_READY),
        .i_st_mem     (st_mem),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_st_data    (st_data),
        .o_ld_data    (ld_data),
        .o_misaligned (misaligned),
        .o_bus_err    (bus_err),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_be     (mem_be),
        .o_mem_wdata  (mem_wdata),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_ok(input logic st, input logic [2:0] f3,
                                      input logic [31:0] a);
        logic legal;
        int size;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        return legal && ((int'(a[1:0]) % size) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3,
                                            input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (!st) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic st, input logic [2:0] f3,
                                                input logic [31:0] d);
        if (!st) return 32'd0;
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int off;
        logic [31:0] byte_v;
        logic [31:0] half_v;
        off = int'(a[1:0]);
        byte_v = (w >> (8 * off)) & 32'hFF;
        half_v = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (byte_v >= 32'd128) ? (byte_v | 32'hFFFF_FF00) : byte_v;
            3'd1: return (half_v >= 32'd32768) ? (half_v | 32'hFFFF_0000) : half_v;
            3'd4: return byte_v;
            3'd5: return half_v;
            default: return w;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Starts just after a falling edge; drives and samples on falling edges.
    // ack_delay = index of the BUSY cycle that gets the ack (-1 = never).
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rdata,
                              input int ack_delay, input logic hold, output obs_t o);
        int k;
        logic first;
        o = '0;
        k = 0;
        first = 1'b1;
        st_mem = st;
        funct3 = f3;
        addr = a;
        st_data = d;
        lsu_VALID = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if ((mem_req || lsu_READY) && !hold) lsu_VALID = 1'b0;
            if (!lsu_READY && (ld_data != 0 || misaligned || bus_err)) o.leak = 1'b1;
            if (!mem_req && (mem_we || mem_be != 0 || mem_addr != 0 || mem_wdata != 0))
                o.leak = 1'b1;
            if (lsu_READY) begin
                o.ready = 1'b1;
                o.latency = 8'(c);
                o.ld = ld_data;
                o.mis = misaligned;
                o.err = bus_err;
                break;
            end
            if (mem_req) begin
                o.req_cycles++;
                if (first) begin
                    o.addr = mem_addr;
                    o.be = mem_be;
                    o.we = mem_we;
                    o.wdata = mem_wdata;
                    first = 1'b0;
                end else if (mem_addr !== o.addr || mem_be !== o.be || mem_we !== o.we ||
                             mem_wdata !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                if (k == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
                k++;
            end else begin
                o.idle_cycles++;
            end
        end
        if (!hold) begin
            lsu_VALID = 1'b0;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        lsu_VALID = 1'b1;
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (lsu_READY !== 1'b0 || ld_data !== 32'd0 || misaligned !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL reset_resp: got ready=%b ld=%h mis=%b err=%b expected all 0", lsu_READY, ld_data, misaligned, bus_err); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 || mem_wdata !== 32'd0)
            $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%h wdata=%h expected all 0", mem_req, mem_we, mem_addr, mem_be, mem_wdata); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
        lsu_VALID = 1'b0;
        mem_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2, 1'b0, o);
        n_checks++; if (o.addr !== 32'h100 || o.be !== 4'hF || o.we !== 1'b0)
            $display("FAIL lb_bus: got addr=%h be=%h we=%b expected 100 f 0", o.addr, o.be, o.we); else n_pass++;
        n_checks++; if (o.ld !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h expected ffffff80", o.ld); else n_pass++;
        n_checks++; if (o.latency !== 8'd4 || o.req_cycles !== 8'd3)
            $display("FAIL lb_timing: got latency=%0d req=%0d expected 4 3", o.latency, o.req_cycles); else n_pass++;
        run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2, 1'b0, o);
        n_checks++; if (o.ld !== 32'h0000_0080) $display("FAIL lbu_data: got %h expected 00000080", o.ld); else n_pass++;
    endtask

    task automatic test_store_half();
        obs_t o;
        run_access(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1'b0, o);
        n_checks++; if (o.we !== 1'b1 || o.be !== 4'hC || o.wdata !== 32'hBEEF_BEEF || o.addr !== 32'h200)
            $display("FAIL sh_bus: got we=%b be=%h wdata=%h addr=%h expected 1 c beefbeef 200", o.we, o.be, o.wdata, o.addr); else n_pass++;
        n_checks++; if (o.latency !== 8'd3 || o.ld !== 32'd0 || o.err !== 1'b0 || o.leak !== 1'b0)
            $display("FAIL sh_resp: got latency=%0d ld=%h err=%b leak=%b expected 3 0 0 0", o.latency, o.ld, o.err, o.leak); else n_pass++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, o);
        n_checks++; if (o.req_cycles !== 8'd0) $display("FAIL mis_req: got %0d req cycles expected 0", o.req_cycles); else n_pass++;
        n_checks++; if (o.ready !== 1'b1 || o.latency !== 8'd1 || o.mis !== 1'b1 || o.ld !== 32'd0 || o.err !== 1'b0)
            $display("FAIL mis_resp: got ready=%b latency=%0d mis=%b ld=%h err=%b expected 1 1 1 0 0", o.ready, o.latency, o.mis, o.ld, o.err); else n_pass++;
        run_access(1'b1, 3'b100, 32'h0000_0100, 32'h55, 32'h0, 0, 1'b0, o);
        n_checks++; if (o.mis !== 1'b1 || o.req_cycles !== 8'd0)
            $display("FAIL illegal_store: got mis=%b req=%0d expected 1 0", o.mis, o.req_cycles); else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, -1, 1'b0, o);
        n_checks++; if (o.req_cycles !== 8'(TIMEOUT) || o.latency !== 8'(TIMEOUT + 1))
            $display("FAIL to_timing: got req=%0d latency=%0d expected %0d %0d", o.req_cycles, o.latency, TIMEOUT, TIMEOUT + 1); else n_pass++;
        n_checks++; if (o.err !== 1'b1 || o.ld !== 32'd0 || o.mis !== 1'b0)
            $display("FAIL to_resp: got err=%b ld=%h mis=%b expected 1 0 0", o.err, o.ld, o.mis); else n_pass++;
        run_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 1'b0, o);
        n_checks++; if (o.err !== 1'b0 || o.ld !== 32'hCAFE_F00D)
            $display("FAIL to_ack_wins: got err=%b ld=%h expected 0 cafef00d", o.err, o.ld); else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] exp_ld;
        r1 = $urandom;
        r2 = $urandom;
        exp_q.push_back(model_load(3'd2, 32'h300, r1));
        exp_q.push_back(model_load(3'd0, 32'h401, r2));
        run_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, r1, 0, 1'b1, o1);
        run_access(1'b0, 3'b000, 32'h0000_0401, 32'h0, r2, 0, 1'b0, o2);
        exp_ld = exp_q.pop_front();
        n_checks++; if (o1.ld !== exp_ld) $display("FAIL b2b_first: got %h expected %h", o1.ld, exp_ld); else n_pass++;
        exp_ld = exp_q.pop_front();
        n_checks++; if (o2.ld !== exp_ld) $display("FAIL b2b_second: got %h expected %h", o2.ld, exp_ld); else n_pass++;
        n_checks++; if (o2.idle_cycles !== 8'd1 || o2.latency !== 8'd3 || o1.latency !== 8'd2)
            $display("FAIL b2b_gap: got idle=%0d lat2=%0d lat1=%0d expected 1 3 2", o2.idle_cycles, o2.latency, o1.latency); else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        logic st;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] r;
        logic [31:0] exp_ld;
        logic ok;
        logic to;
        int dly;
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            d = $urandom;
            r = $urandom;
            dly = $urandom_range(0, 5);
            ok = model_ok(st, f3, a);
            to = (dly >= TIMEOUT);
            exp_q.push_back((!ok || st || to) ? 32'd0 : model_load(f3, a, r));
            run_access(st, f3, a, d, r, dly, 1'b0, o);
            exp_ld = exp_q.pop_front();
            n_checks++; if (o.ready !== 1'b1 || o.ld !== exp_ld || o.mis !== !ok)
                $display("FAIL rnd_resp[%0d]: got ready=%b ld=%h mis=%b expected 1 %h %b", i, o.ready, o.ld, o.mis, exp_ld, !ok); else n_pass++;
            n_checks++; if (o.unstable !== 1'b0 || o.leak !== 1'b0)
                $display("FAIL rnd_hygiene[%0d]: got unstable=%b leak=%b expected 0 0", i, o.unstable, o.leak); else n_pass++;
            if (ok) begin
                n_checks++; if (o.err !== to || o.req_cycles !== 8'(to ? TIMEOUT : dly + 1) || o.latency !== 8'(to ? TIMEOUT + 1 : dly + 2))
                    $display("FAIL rnd_timing[%0d]: got err=%b req=%0d lat=%0d expected %b %0d %0d", i, o.err, o.req_cycles, o.latency, to, to ? TIMEOUT : dly + 1, to ? TIMEOUT + 1 : dly + 2); else n_pass++;
                n_checks++; if (o.addr !== (a & 32'hFFFF_FFFC) || o.be !== model_be(st, f3, a) || o.we !== st || o.wdata !== model_wdata(st, f3, d))
                    $display("FAIL rnd_bus[%0d]: got addr=%h be=%h we=%b wdata=%h expected %h %h %b %h", i, o.addr, o.be, o.we, o.wdata, a & 32'hFFFF_FFFC, model_be(st, f3, a), st, model_wdata(st, f3, d)); else n_pass++;
            end else begin
                n_checks++; if (o.req_cycles !== 8'd0 || o.latency !== 8'd1 || o.err !== 1'b0)
                    $display("FAIL rnd_mis[%0d]: got req=%0d lat=%0d err=%b expected 0 1 0", i, o.req_cycles, o.latency, o.err); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic bad;
        bad = 1'b0;
        st_mem = 1'b0;
        funct3 = 3'b010;
        addr = 32'h0000_0500;
        lsu_VALID = 1'b1;
        @(negedge clk);
        lsu_VALID = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_busy_pre: got req=%b expected 1", mem_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 || lsu_READY !== 1'b0)
            $display("FAIL rst_busy_drop: got req=%b addr=%h be=%h ready=%b expected 0 0 0 0", mem_req, mem_addr, mem_be, lsu_READY); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (lsu_READY !== 1'b0 || mem_req !== 1'b0 || ld_data !== 32'd0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) $display("FAIL rst_late_ack: got activity=%b expected 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
